transmit_data: RTL and testbench

- Serial transmitter that feeds the bit-serial receive path.
- On a start request it reads NUM_BITS consecutive words from a data memory read port and shifts bit 0 of each word onto a serial data line, one bit per slow-clock period.
- It generates the slow serial clock itself from the system clock, and exports it alongside the data.
- Data changes only on ser_clk falling edges, so it is stable when the far end samples on the ser_clk rising edge.

---
 rtl/transmit_data_if.sv | 36 +++
 rtl/transmit_data.sv | 109 ++++++++++
 tb/tb_transmit_data.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/transmit_data_if.sv
// Transmitter bus bundle: start/busy/done control, memory read port,
// serial clock/data outputs and debug bit index.
interface transmit_data_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_q;
  logic              ser_clk;
  logic              ser_data;
  logic              busy;
  logic              done;
  logic [3:0]        index_out;

  modport master (
    input  start,
    input  mem_q,
    output mem_addr,
    output ser_clk,
    output ser_data,
    output busy,
    output done,
    output index_out
  );

  modport slave (
    output start,
    output mem_q,
    input  mem_addr,
    input  ser_clk,
    input  ser_data,
    input  busy,
    input  done,
    input  index_out
  );
endinterface

// File: rtl/transmit_data.sv
// Serial transmitter: streams bit 0 of NUM_BITS memory words on ser_data,
// changing on ser_clk falls. Ports: clk, reset (sync, high), bus (master).
module transmit_data #(
  parameter int CLK_DIV  = 25000000,
  parameter int NUM_BITS = 13,
  parameter int ADDR_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  transmit_data_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WAIT_FALL,
    DRAIN
  } state_t;

  localparam logic [31:0] DIV =
    32'(CLK_DIV);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_BITS - 1);

  state_t            state;
  logic [31:0]       cnt;
  logic              sclk;
  logic              sdata;
  logic              busy_q;
  logic              done_q;
  logic              bit_buf;
  logic [ADDR_W-1:0] index;
  logic              div_hit;
  logic              fall_evt;
  logic              unused_q;

  assign div_hit  = (cnt == DIV);
  assign fall_evt = div_hit & sclk;
  assign unused_q = ^bus.mem_q[31:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bit_buf <= 1'b0;
      index   <= '0;
    end else begin
      done_q <= 1'b0;
      if (div_hit) begin
        cnt  <= '0;
        sclk <= ~sclk;
      end else begin
        cnt <= cnt + 32'd1;
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            index  <= '0;
            busy_q <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          bit_buf <= bus.mem_q[0];
          state   <= WAIT_FALL;
        end
        WAIT_FALL: begin
          if (fall_evt) begin
            sdata <= bit_buf;
            if (index == LAST) begin
              state <= DRAIN;
            end else begin
              index <= index + ADDR_W'(1);
              state <= FETCH;
            end
          end
        end
        DRAIN: begin
          // last bit is sampled on the rise before this fall
          if (fall_evt) begin
            sdata  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = index;
  assign bus.ser_clk   = sclk;
  assign bus.ser_data  = sdata;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.index_out = index[3:0];

endmodule

// File: tb/tb_transmit_data.sv
// Scoreboard bench for transmit_data: directed transfers, divider,
// handshake, reset abort and back-to-back operation.
module tb_transmit_data;
  localparam int CD = 3;
  localparam int NB = 13;
  localparam int AW = 12;
  localparam int HP = CD + 1;

  typedef struct {
    logic          b;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  transmit_data_if #(.ADDR_W(AW)) a_if ();
  transmit_data_if #(.ADDR_W(AW)) b_if ();

  transmit_data #(
    .CLK_DIV(CD), .NUM_BITS(NB), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .bus(a_if.master)
  );

  transmit_data #(
    .CLK_DIV(CD), .NUM_BITS(2), .ADDR_W(AW)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(b_if.master)
  );

  logic [31:0] mem_a [NB];
  logic [31:0] mem_b [2];

  always @(posedge clk) begin
    a_if.mem_q <= mem_a[a_if.mem_addr];
    b_if.mem_q <= mem_b[b_if.mem_addr[0]];
  end

  exp_t q[$];
  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int bcnt = 0;
  int bits_seen = 0;
  int done_seen = 0;
  int exp_done = 0;
  int last_fall = 0;
  bit prev_sclk = 1'b0;
  bit armed = 1'b0;
  bit chk_low = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: a bit counts once driven on a fall well after start,
  // and is checked on the next ser_clk rise.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      bcnt = 0;
      armed = 1'b0;
      chk_low = 1'b0;
      prev_sclk = 1'b0;
    end else begin
      if (chk_low) begin
        chk("done_width", a_if.done, 0);
        chk_low = 1'b0;
      end
      bcnt = a_if.busy ? bcnt + 1 : 0;
      if (prev_sclk && !a_if.ser_clk &&
          a_if.busy && bcnt >= 4) begin
        armed = 1'b1;
        last_fall = cyc;
      end
      if (!prev_sclk && a_if.ser_clk && armed) begin
        armed = 1'b0;
        bits_seen++;
        if (q.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          e = q.pop_front();
          chk("ser_data", a_if.ser_data, e.b);
          chk("mem_addr", a_if.mem_addr, e.addr);
          chk("index_out", a_if.index_out,
              e.addr[3:0]);
        end
      end
      if (a_if.done) begin
        done_seen++;
        chk("done_delay", cyc - last_fall, 2 * HP);
        chk("busy_at_done", a_if.busy, 0);
        chk("data_at_done", a_if.ser_data, 0);
        chk_low = 1'b1;
      end
      prev_sclk = a_if.ser_clk;
    end
  end

  task automatic start_xfer();
    exp_t e;
    for (int k = 0; k < NB; k++) begin
      e.b = mem_a[k][0];
      e.addr = (k == NB - 1) ? AW'(NB - 1) : AW'(k + 1);
      q.push_back(e);
    end
    exp_done++;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    chk("busy_on_start", a_if.busy, 1);
    chk("addr_on_start", a_if.mem_addr, 0);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (a_if.done) seen = 1'b1;
    end
    chk("done_timeout", seen, 1);
    repeat (3) @(negedge clk);
    chk("bits_left", q.size(), 0);
    chk("idle_data", a_if.ser_data, 0);
    chk("idle_busy", a_if.busy, 0);
  endtask

  task automatic load_pat(input logic [12:0] pat);
    for (int k = 0; k < NB; k++)
      mem_a[k] = ($urandom() & 32'hFFFF_FFFE) |
                 32'(pat[12 - k]);
  endtask

  task automatic load_all(input logic [31:0] w);
    for (int k = 0; k < NB; k++) mem_a[k] = w;
  endtask

  initial begin
    int base;
    bit seen;
    int nrise;
    logic [2:0] bseq;
    bit pclk;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    load_all(32'h0);
    mem_b[0] = 32'h0000_0000;
    mem_b[1] = 32'h0000_0001;
    repeat (3) @(negedge clk);
    chk("rst_ser_clk", a_if.ser_clk, 0);
    chk("rst_ser_data", a_if.ser_data, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_addr", a_if.mem_addr, 0);
    chk("rst_index", a_if.index_out, 0);
    chk("rst_b_busy", b_if.busy, 0);
    reset = 1'b0;

    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("divider", a_if.ser_clk, (k / 4) % 2);
    end

    load_pat(13'b1011001011101);
    base = bits_seen;
    start_xfer();
    repeat (40) @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_done();
    chk("bits_sent", bits_seen - base, NB);

    load_all(32'hFFFF_FFFE);
    start_xfer();
    wait_done();
    load_all(32'h0000_0001);
    start_xfer();
    wait_done();

    load_pat(13'b0110100111010);
    base = bits_seen;
    start_xfer();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bits_seen - base >= 6) seen = 1'b1;
    end
    chk("bit5_timeout", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", a_if.busy, 0);
    chk("abort_ser_clk", a_if.ser_clk, 0);
    chk("abort_ser_data", a_if.ser_data, 0);
    chk("abort_addr", a_if.mem_addr, 0);
    chk("abort_done", a_if.done, 0);
    q.delete();
    exp_done--;
    repeat (5) @(negedge clk);
    start_xfer();
    wait_done();

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    b_if.start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (b_if.done) seen = 1'b1;
    end
    chk("b2b_done1_timeout", seen, 1);
    nrise = 0;
    bseq = 3'b000;
    pclk = b_if.ser_clk;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 1) chk("b2b_reaccept", b_if.busy, 1);
      if (!pclk && b_if.ser_clk) begin
        nrise++;
        bseq = {bseq[1:0], b_if.ser_data};
      end
      pclk = b_if.ser_clk;
      if (i == 24) chk("b2b_done2", b_if.done, 1);
      else if (b_if.done) chk("b2b_early_done", 1, 0);
    end
    b_if.start = 1'b0;
    chk("b2b_rises", nrise, 3);
    chk("b2b_bits", bseq, 3'b001);

    repeat (5) @(negedge clk);
    chk("done_count", done_seen, exp_done);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end
endmodule
